// File: rtl/imm_extend_unit.sv
// Registered immediate-extension stage with valid/ready on both sides and a two-entry skid buffer.
// Optional statistics ports (count_o, stall_o) are built when IMM_EXTEND_STATS_EN is defined.
module imm_extend_unit #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [TAG_W-1:0] tag_o
`ifdef IMM_EXTEND_STATS_EN
    ,
    output logic [15:0]      count_o,
    output logic             stall_o
`endif
);

    localparam int unsigned E = OUT_W - IN_W;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    generate
        if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_params
            $error("imm_extend_unit: requires IN_W >= 2 and OUT_W >= IN_W + 2");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   sext, zext, ext_data;
    logic [OUT_W-1:0]   out_q, skid_q;
    logic [TAG_W-1:0]   tag_q, skid_tag_q;
    logic               in_fire, out_fire;
    logic               load_out, load_skid, pop_skid;

    // Upper mode shifts the zero-extended field up by IN_W; bits past OUT_W fall off.
    always_comb begin
        zext = OUT_W'(data_i);
        sext = {{E{data_i[IN_W-1]}}, data_i};
        case (mode_i)
            2'b00:   ext_data = sext;
            2'b01:   ext_data = zext;
            2'b10:   ext_data = zext << IN_W;
            default: ext_data = sext << 2;
        endcase
    end

    assign valid_o  = (state_q != EMPTY);
    assign ready_o  = (state_q != TWO) & ~rst_i;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;
    assign data_o   = out_q;
    assign tag_o    = tag_q;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_out = 1'b1;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    pop_skid = 1'b1;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            out_q      <= '0;
            tag_q      <= '0;
            skid_q     <= '0;
            skid_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_q <= ext_data;
                tag_q <= tag_i;
            end else if (pop_skid) begin
                out_q <= skid_q;
                tag_q <= skid_tag_q;
            end
            if (load_skid) begin
                skid_q     <= ext_data;
                skid_tag_q <= tag_i;
            end
        end
    end

`ifdef IMM_EXTEND_STATS_EN
    logic [15:0] count_q;
    logic        stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            stall_q <= 1'b0;
        end else begin
            if (out_fire && count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
            end
            stall_q <= (state_q == TWO) & ~ready_i;
        end
    end

    assign count_o = count_q;
    assign stall_o = stall_q;
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed, table-driven bench for imm_extend_unit (default 16/32/5 configuration).
module tb_imm_extend_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_i;
    logic [1:0]  mode_i;
    logic [4:0]  tag_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [4:0]  tag_o;
`ifdef IMM_EXTEND_STATS_EN
    logic [15:0] count_o;
    logic        stall_o;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk_i = ~clk_i;

    imm_extend_unit #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .mode_i  (mode_i),
        .tag_i   (tag_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .tag_o   (tag_o)
`ifdef IMM_EXTEND_STATS_EN
        ,
        .count_o (count_o),
        .stall_o (stall_o)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs and samples both land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] m, input logic [4:0] t);
        valid_i = 1'b1;
        data_i  = d;
        mode_i  = m;
        tag_i   = t;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h8001, 2'b00, 5'd1,  32'hFFFF8001};
        vecs[1] = '{16'h8001, 2'b01, 5'd2,  32'h00008001};
        vecs[2] = '{16'h8001, 2'b10, 5'd3,  32'h80010000};
        vecs[3] = '{16'hFFFF, 2'b11, 5'd4,  32'hFFFFFFFC};
        vecs[4] = '{16'h7FFF, 2'b11, 5'd5,  32'h0001FFFC};
        vecs[5] = '{16'h8000, 2'b11, 5'd6,  32'hFFFE0000};
        vecs[6] = '{16'h1234, 2'b10, 5'd7,  32'h12340000};
        vecs[7] = '{16'h7FFF, 2'b00, 5'd8,  32'h00007FFF};
        vecs[8] = '{16'hFFFF, 2'b01, 5'd9,  32'h0000FFFF};
        vecs[9] = '{16'h0000, 2'b00, 5'd31, 32'h00000000};

        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 'x;
        mode_i  = 2'b00;
        tag_i   = '0;

        // Reset state
        step();
        step();
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o",  data_o,       32'd0);
        check("rst_tag_o",   32'(tag_o),   32'd0);
        check("rst_ready_gated", 32'(ready_o), 32'd0);
`ifdef IMM_EXTEND_STATS_EN
        check("rst_count_o", 32'(count_o), 32'd0);
        check("rst_stall_o", 32'(stall_o), 32'd0);
`endif
        rst_i = 1'b0;
        #1;
        check("post_rst_ready_o", 32'(ready_o), 32'd1);

        // Mode table: one transaction at a time, result visible one cycle after in_fire.
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].data, vecs[i].mode, vecs[i].tag);
            step();
            valid_i = 1'b0;
            data_i  = 'x;
            check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'd1);
            check($sformatf("vec%0d_data", i),  data_o,       vecs[i].exp);
            check($sformatf("vec%0d_tag", i),   32'(tag_o),   32'(vecs[i].tag));
            step();
            check($sformatf("vec%0d_drain", i), 32'(valid_o), 32'd0);
        end

        // Back-to-back stream of 10 with ready_i held high.
        for (int i = 0; i < 10; i++) begin
            push(16'(i), 2'b01, 5'(i));
            check($sformatf("b2b%0d_ready", i), 32'(ready_o), 32'd1);
            step();
            check($sformatf("b2b%0d_valid", i), 32'(valid_o), 32'd1);
            check($sformatf("b2b%0d_tag", i),   32'(tag_o),   32'(i));
            check($sformatf("b2b%0d_data", i),  data_o,       32'(i));
        end
        valid_i = 1'b0;
        step();
        check("b2b_end_valid", 32'(valid_o), 32'd0);

        // Backpressure: fill both entries, then drain in order.
        ready_i = 1'b0;
        push(16'h0001, 2'b01, 5'd1);
        step();
        push(16'h0002, 2'b01, 5'd2);
        step();
        check("bp_ready_o_two", 32'(ready_o), 32'd0);
        check("bp_valid_o",     32'(valid_o), 32'd1);
        check("bp_data_A",      data_o,       32'h00000001);
`ifdef IMM_EXTEND_STATS_EN
        step();
        check("stall_o_set", 32'(stall_o), 32'd1);
`endif
        push(16'hDEAD, 2'b01, 5'd9);
        step();
        valid_i = 1'b0;
        check("bp_hold_data", data_o,     32'h00000001);
        check("bp_hold_tag",  32'(tag_o), 32'd1);
        ready_i = 1'b1;
        step();
        check("bp_data_B", data_o,       32'h00000002);
        check("bp_tag_B",  32'(tag_o),   32'd2);
        check("bp_ready_one", 32'(ready_o), 32'd1);
        step();
        check("bp_drained", 32'(valid_o), 32'd0);

        // Simultaneous in/out while holding one entry.
        ready_i = 1'b0;
        push(16'h0011, 2'b01, 5'd3);
        step();
        push(16'h0022, 2'b01, 5'd4);
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("sim_data",  data_o,        32'h00000022);
        check("sim_tag",   32'(tag_o),    32'd4);
        check("sim_ready", 32'(ready_o),  32'd1);
        step();
        check("sim_no_skid", 32'(valid_o), 32'd0);

        // Reset while full, with a handshake attempt in the same cycle.
        ready_i = 1'b0;
        push(16'h00AA, 2'b01, 5'd5);
        step();
        push(16'h00BB, 2'b01, 5'd6);
        step();
        check("rmid_two", 32'(ready_o), 32'd0);
        rst_i   = 1'b1;
        ready_i = 1'b1;
        push(16'h00CC, 2'b01, 5'd7);
        step();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        check("rmid_valid", 32'(valid_o), 32'd0);
        check("rmid_data",  data_o,       32'd0);
        check("rmid_tag",   32'(tag_o),   32'd0);
        #1;
        check("rmid_ready", 32'(ready_o), 32'd1);
        step();
        check("rmid_no_old", 32'(valid_o), 32'd0);
        step();
        check("rmid_no_old2", 32'(valid_o), 32'd0);

`ifdef IMM_EXTEND_STATS_EN
        // Saturating out_fire counter.
        do_reset();
        ready_i = 1'b1;
        push(16'h0001, 2'b00, 5'd0);
        repeat (6) step();
        check("count_5", 32'(count_o), 32'd5);
        repeat (65540) step();
        valid_i = 1'b0;
        check("count_sat", 32'(count_o), 32'h0000FFFF);
        step();
        check("count_hold", 32'(count_o), 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
